// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-colour stage: background modes,
// colour width and the 3-bit colour-index to RGB mapping.
package vga_pkg;

  localparam int COLOR_W = 2;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Each index bit drives one channel at full or zero intensity.
  function automatic rgb_t idx_to_rgb(input logic [2:0] idx);
    rgb_t c;
    c.r = {COLOR_W{idx[2]}};
    c.g = {COLOR_W{idx[1]}};
    c.b = {COLOR_W{idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position/direction held between frames,
// stepped on en with clamp-and-reverse at 0 and LIMIT.
module bounce_axis #(
  parameter int POS_W = 10,
  parameter int LIMIT = 608,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             bounce
);

  localparam logic [POS_W:0] LIMIT_W = LIMIT[POS_W:0];
  localparam logic [POS_W:0] STEP_W  = STEP[POS_W:0];

  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [POS_W:0]   pos_ext;
  logic [POS_W:0]   sum;

  // dir 0 moves toward LIMIT, dir 1 moves toward 0; the extra sum bit
  // keeps the upper compare free of wrap-around.
  always_comb begin
    pos_d   = pos_q;
    dir_d   = dir_q;
    bounce  = 1'b0;
    pos_ext = {1'b0, pos_q};
    sum     = pos_ext + STEP_W;
    if (en) begin
      if (!dir_q) begin
        if (sum >= LIMIT_W) begin
          pos_d  = LIMIT_W[POS_W-1:0];
          dir_d  = 1'b1;
          bounce = 1'b1;
        end else begin
          pos_d = sum[POS_W-1:0];
        end
      end else begin
        if (pos_ext <= STEP_W) begin
          pos_d  = '0;
          dir_d  = 1'b0;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q - STEP_W[POS_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      dir_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/vga_bounce_renderer.sv
// Pixel-colour stage after the VGA timing generator: background pattern plus
// a bouncing box, two registered stages with sync/enable kept aligned.
module vga_bounce_renderer
  import vga_pkg::*;
#(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int BOX_SIZE    = 32,
  parameter int STEP        = 2,
  parameter int CHECK_SHIFT = 5
) (
  input  logic               pix_clk,
  input  logic               reset,
  input  logic [9:0]         h_sel,
  input  logic [8:0]         v_sel,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               display_en,
  input  logic [1:0]         mode,
  input  logic               pause,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               hsync,
  output logic               vsync,
  output logic               de_out,
  output logic               frame_tick
);

  localparam logic [10:0] BOX_X_W = BOX_SIZE[10:0];
  localparam logic [9:0]  BOX_Y_W = BOX_SIZE[9:0];

  logic        vsync_prev_q, vsync_prev_d;
  logic        frame_tick_q, frame_tick_d;
  mode_e       mode_q, mode_d;
  logic        pause_q, pause_d;
  logic [2:0]  colour_idx_q, colour_idx_d;
  logic        frame_evt;
  logic        move_en;

  logic [9:0]  box_x;
  logic [8:0]  box_y;
  logic        dir_x, dir_y;
  logic        bounce_x, bounce_y;

  logic [10:0] x_end;
  logic [9:0]  y_end;
  logic        in_box;

  logic [2:0]  h_hi_p1_q, h_hi_p1_d;
  logic [1:0]  v_hi_p1_q, v_hi_p1_d;
  logic        chk_p1_q, chk_p1_d;
  logic        in_box_p1_q, in_box_p1_d;
  logic        de_p1_q, de_p1_d;
  logic        hs_p1_q, hs_p1_d;
  logic        vs_p1_q, vs_p1_d;

  rgb_t        rgb_p2_q, rgb_p2_d;
  logic        de_p2_q, de_p2_d;
  logic        hs_p2_q, hs_p2_d;
  logic        vs_p2_q, vs_p2_d;

  rgb_t        bg;
  logic [2:0]  bar_idx;

  assign frame_evt = vsync_prev_q & ~vsync_in;
  // pause_q still holds the previous frame's sample on the event cycle.
  assign move_en   = frame_evt & ~pause_q;

  bounce_axis #(.POS_W(10), .LIMIT(WIDTH - BOX_SIZE), .STEP(STEP)) u_axis_x (
    .clk    (pix_clk),
    .rst_n  (reset),
    .en     (move_en),
    .pos    (box_x),
    .dir    (dir_x),
    .bounce (bounce_x)
  );

  bounce_axis #(.POS_W(9), .LIMIT(HEIGHT - BOX_SIZE), .STEP(STEP)) u_axis_y (
    .clk    (pix_clk),
    .rst_n  (reset),
    .en     (move_en),
    .pos    (box_y),
    .dir    (dir_y),
    .bounce (bounce_y)
  );

  always_comb begin
    vsync_prev_d = vsync_in;
    frame_tick_d = frame_evt;
    mode_d       = frame_evt ? mode_e'(mode) : mode_q;
    pause_d      = frame_evt ? pause : pause_q;
    colour_idx_d = colour_idx_q;
    if (move_en && (bounce_x || bounce_y)) begin
      colour_idx_d = (colour_idx_q == 3'd7) ? 3'd1 : colour_idx_q + 3'd1;
    end
  end

  // Stage 1: capture stream, box hit and the coordinate bits the patterns need
  always_comb begin
    x_end       = {1'b0, box_x} + BOX_X_W;
    y_end       = {1'b0, box_y} + BOX_Y_W;
    in_box      = (h_sel >= box_x) && ({1'b0, h_sel} < x_end) &&
                  (v_sel >= box_y) && ({1'b0, v_sel} < y_end);
    in_box_p1_d = in_box;
    h_hi_p1_d   = h_sel[9:7];
    v_hi_p1_d   = v_sel[8:7];
    chk_p1_d    = h_sel[CHECK_SHIFT] ^ v_sel[CHECK_SHIFT];
    de_p1_d     = display_en;
    hs_p1_d     = hsync_in;
    vs_p1_d     = vsync_in;
  end

  // Stage 2: pick background, overlay box, blank outside the visible area
  always_comb begin
    bg      = '0;
    bar_idx = h_hi_p1_q + 3'd1;
    case (mode_q)
      MODE_BLACK: bg = '0;
      MODE_CHECK: bg = chk_p1_q ? '1 : '0;
      MODE_BARS:  bg = idx_to_rgb(bar_idx);
      MODE_GRAD: begin
        bg.r = h_hi_p1_q[2:1];
        bg.g = v_hi_p1_q;
        bg.b = '0;
      end
      default:    bg = '0;
    endcase
    if (!de_p1_q) begin
      rgb_p2_d = '0;
    end else if (in_box_p1_q) begin
      rgb_p2_d = idx_to_rgb(colour_idx_q);
    end else begin
      rgb_p2_d = bg;
    end
    de_p2_d = de_p1_q;
    hs_p2_d = hs_p1_q;
    vs_p2_d = vs_p1_q;
  end

  always_ff @(posedge pix_clk or negedge reset) begin
    if (!reset) begin
      vsync_prev_q <= 1'b1;
      frame_tick_q <= 1'b0;
      mode_q       <= MODE_BLACK;
      pause_q      <= 1'b0;
      colour_idx_q <= 3'd1;
      h_hi_p1_q    <= '0;
      v_hi_p1_q    <= '0;
      chk_p1_q     <= 1'b0;
      in_box_p1_q  <= 1'b0;
      de_p1_q      <= 1'b0;
      hs_p1_q      <= 1'b1;
      vs_p1_q      <= 1'b1;
      rgb_p2_q     <= '0;
      de_p2_q      <= 1'b0;
      hs_p2_q      <= 1'b1;
      vs_p2_q      <= 1'b1;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      frame_tick_q <= frame_tick_d;
      mode_q       <= mode_d;
      pause_q      <= pause_d;
      colour_idx_q <= colour_idx_d;
      h_hi_p1_q    <= h_hi_p1_d;
      v_hi_p1_q    <= v_hi_p1_d;
      chk_p1_q     <= chk_p1_d;
      in_box_p1_q  <= in_box_p1_d;
      de_p1_q      <= de_p1_d;
      hs_p1_q      <= hs_p1_d;
      vs_p1_q      <= vs_p1_d;
      rgb_p2_q     <= rgb_p2_d;
      de_p2_q      <= de_p2_d;
      hs_p2_q      <= hs_p2_d;
      vs_p2_q      <= vs_p2_d;
    end
  end

  assign r          = rgb_p2_q.r;
  assign g          = rgb_p2_q.g;
  assign b          = rgb_p2_q.b;
  assign hsync      = hs_p2_q;
  assign vsync      = vs_p2_q;
  assign de_out     = de_p2_q;
  assign frame_tick = frame_tick_q;

endmodule
